// File: rtl/alu_share_arbiter.sv
// Round-robin front end that time-shares one external ALU between two requesters.
// One transaction in flight: operands are registered into the ALU and the result is registered out of it.
module alu_share_arbiter #(
  parameter int W      = 16,
  parameter int OPW    = 4,
  parameter int MAX_OP = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic [OPW-1:0] req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  input  logic [OPW-1:0] req1_op,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [W-1:0]   rsp0_c,
  output logic           rsp0_bcond,
  output logic           rsp0_err,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [W-1:0]   rsp1_c,
  output logic           rsp1_bcond,
  output logic           rsp1_err,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_c,
  input  logic           alu_bcond
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_nxt;
  logic           last_gnt, cur, gnt, accept, bad_op;
  logic [W-1:0]   a_q, b_q;
  logic [OPW-1:0] op_q;

  assign bad_op = (op_q > OPW'(MAX_OP));
  assign alu_a  = a_q;
  assign alu_b  = b_q;
  // Illegal opcodes never reach the ALU; it sees a harmless ADD instead.
  assign alu_op = bad_op ? '0 : op_q;
  assign accept = req0_ready | req1_ready;

  always_comb begin
    gnt = ~last_gnt;
    if (req0_valid && !req1_valid)      gnt = 1'b0;
    else if (req1_valid && !req0_valid) gnt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = req0_valid & ~gnt;
        req1_ready = req1_valid & gnt;
        if (req0_ready || req1_ready) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp0_valid = ~cur;
        rsp1_valid = cur;
        if (cur ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt   <= 1'b1;
      cur        <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rsp0_c     <= '0;
      rsp0_bcond <= 1'b0;
      rsp0_err   <= 1'b0;
      rsp1_c     <= '0;
      rsp1_bcond <= 1'b0;
      rsp1_err   <= 1'b0;
    end else begin
      if (accept) begin
        a_q      <= gnt ? req1_a  : req0_a;
        b_q      <= gnt ? req1_b  : req0_b;
        op_q     <= gnt ? req1_op : req0_op;
        cur      <= gnt;
        last_gnt <= gnt;
      end
      // Result registers are per port so an idle port keeps its last answer.
      if (state == EXEC) begin
        if (!cur) begin
          rsp0_c     <= bad_op ? '0 : alu_c;
          rsp0_bcond <= bad_op ? 1'b0 : alu_bcond;
          rsp0_err   <= bad_op;
        end else begin
          rsp1_c     <= bad_op ? '0 : alu_c;
          rsp1_bcond <= bad_op ? 1'b0 : alu_bcond;
          rsp1_err   <= bad_op;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized checks of alu_share_arbiter against a transaction-level reference model.
module tb_alu_share_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        v0 = 0, v1 = 0, rr0 = 1, rr1 = 1;
  logic [15:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [3:0]  op0 = 0, op1 = 0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_c, rsp1_c, alu_a, alu_b, alu_c;
  logic        rsp0_bcond, rsp1_bcond, rsp0_err, rsp1_err, alu_bcond;
  logic [3:0]  alu_op;

  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(req0_ready), .req0_a(a0), .req0_b(b0), .req0_op(op0),
    .req1_valid(v1), .req1_ready(req1_ready), .req1_a(a1), .req1_b(b1), .req1_op(op1),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rr0), .rsp0_c(rsp0_c), .rsp0_bcond(rsp0_bcond), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rr1), .rsp1_c(rsp1_c), .rsp1_bcond(rsp1_bcond), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .alu_bcond(alu_bcond)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] alu_fn(logic [15:0] a, logic [15:0] b, logic [3:0] op);
    logic [15:0] c;
    logic        bc;
    c  = '0;
    bc = 1'b0;
    case (op)
      4'd0:  c = a + b;
      4'd1:  c = a - b;
      4'd2:  c = a & b;
      4'd3:  c = a | b;
      4'd4:  c = ~a;
      4'd5:  c = -a;
      4'd6:  c = a << b[3:0];
      4'd7:  c = a >> b[3:0];
      4'd8:  c = {b[7:0], 8'h00};
      4'd9:  bc = (a != b);
      4'd10: bc = (a == b);
      4'd11: bc = ($signed(a) > 0);
      4'd12: bc = ($signed(a) < 0);
      default: ;
    endcase
    return {bc, c};
  endfunction

  // Stand-in ALU driven only from the DUT's ALU pins.
  always_comb {alu_bcond, alu_c} = alu_fn(alu_a, alu_b, alu_op);

  int n_cmp = 0, n_bad = 0;
  int since = -1;            // -1: no transaction; 0: cycle after accept; >=1: response offered
  bit lastg = 1, curg = 0, auto0 = 0, auto1 = 0;
  logic [15:0] la, lb, ea0, ea1;
  logic [3:0]  lop;
  logic        eb0, eb1, ee0, ee1;
  int          gnt_log[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s: observed timeout expected completion", tag);
  endtask

  task automatic new0();
    a0 = 16'($urandom); b0 = 16'($urandom); op0 = 4'($urandom_range(0, 15));
  endtask
  task automatic new1();
    a1 = 16'($urandom); b1 = 16'($urandom); op1 = 4'($urandom_range(0, 15));
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the rising edge.
  task automatic cyc();
    logic g, er0, er1;
    logic [16:0] r;
    @(negedge clk);
    g   = (v0 && !v1) ? 1'b0 : (v1 && !v0) ? 1'b1 : !lastg;
    er0 = (since < 0) && v0 && !g;
    er1 = (since < 0) && v1 && g;
    chk("req0_ready", req0_ready, er0);
    chk("req1_ready", req1_ready, er1);
    chk("both_ready", req0_ready & req1_ready, 0);
    chk("rsp0_valid", rsp0_valid, (since >= 1) && !curg);
    chk("rsp1_valid", rsp1_valid, (since >= 1) && curg);
    chk("rsp0_c", rsp0_c, ea0);  chk("rsp0_bcond", rsp0_bcond, eb0);  chk("rsp0_err", rsp0_err, ee0);
    chk("rsp1_c", rsp1_c, ea1);  chk("rsp1_bcond", rsp1_bcond, eb1);  chk("rsp1_err", rsp1_err, ee1);
    if (since == 0) begin
      chk("alu_a", alu_a, la);
      chk("alu_b", alu_b, lb);
      chk("alu_op", alu_op, (lop > 12) ? 4'd0 : lop);
    end
    @(posedge clk);
    if (!rst_n) begin
      since = -1; lastg = 1; curg = 0;
      ea0 = 0; eb0 = 0; ee0 = 0; ea1 = 0; eb1 = 0; ee1 = 0;
    end else if (since < 0) begin
      if (er0 || er1) begin
        la = g ? a1 : a0; lb = g ? b1 : b0; lop = g ? op1 : op0;
        curg = g; lastg = g; since = 0;
        gnt_log.push_back(int'(g));
      end
    end else if (since == 0) begin
      r = (lop > 12) ? 17'd0 : alu_fn(la, lb, lop);
      if (!curg) begin ea0 = r[15:0]; eb0 = r[16]; ee0 = (lop > 12); end
      else       begin ea1 = r[15:0]; eb1 = r[16]; ee1 = (lop > 12); end
      since = 1;
    end else if (curg ? rr1 : rr0) begin
      since = -1;
    end else begin
      since++;
    end
    #1;
    if (er0) begin if (auto0) new0(); else v0 = 0; end
    if (er1) begin if (auto1) new1(); else v1 = 0; end
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    while (!(since < 0 && !v0 && !v1) && n < 100) begin cyc(); n++; end
    if (n >= 100) timeout(tag);
  endtask

  initial begin
    ea0 = 0; eb0 = 0; ee0 = 0; ea1 = 0; eb1 = 0; ee1 = 0;
    la = 0; lb = 0; lop = 0;
    rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
    chk("rst_alu_a", alu_a, 0); chk("rst_alu_b", alu_b, 0); chk("rst_alu_op", alu_op, 0);
    cyc();

    // single request on port 0
    v0 = 1; a0 = 5; b0 = 3; op0 = 0;
    cyc();
    chk("t1_accepted", since, 0);
    cyc();
    chk("t1_rsp_valid", rsp0_valid, 1);
    drain("t1_drain");
    chk("t1_c", rsp0_c, 8); chk("t1_bcond", rsp0_bcond, 0); chk("t1_err", rsp0_err, 0);

    // tie after a port-0 grant goes to port 1
    gnt_log.delete();
    v0 = 1; a0 = 7; b0 = 2; op0 = 1;
    v1 = 1; a1 = 4; b1 = 4; op1 = 10;
    drain("t2_drain");
    chk("t2_c0", rsp0_c, 5); chk("t2_c1", rsp1_c, 0); chk("t2_bc1", rsp1_bcond, 1);
    chk("t2_n", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin chk("t2_g0", gnt_log[0], 1); chk("t2_g1", gnt_log[1], 0); end

    // both ports held valid: strict alternation
    gnt_log.delete();
    auto0 = 1; auto1 = 1; new0(); new1(); v0 = 1; v1 = 1;
    for (int i = 0; i < 60 && gnt_log.size() < 6; i++) cyc();
    auto0 = 0; auto1 = 0;
    if (gnt_log.size() < 6) timeout("t3_grants");
    else for (int i = 0; i < 6; i++) chk($sformatf("t3_g%0d", i), gnt_log[i], (gnt_log[0] + i) % 2);
    drain("t3_drain");

    // illegal opcode then BLZ on port 1
    v1 = 1; a1 = 16'h1234; b1 = 16'h0042; op1 = 13;
    drain("t4a");
    chk("t4_err", rsp1_err, 1); chk("t4_c", rsp1_c, 0); chk("t4_bc", rsp1_bcond, 0);
    v1 = 1; a1 = 16'hFFFD; b1 = 0; op1 = 12;
    drain("t4b");
    chk("t4b_bc", rsp1_bcond, 1); chk("t4b_err", rsp1_err, 0);

    // response backpressure blocks new grants
    begin
      logic [15:0] snap;
      rr0 = 0; v0 = 1; a0 = 100; b0 = 23; op0 = 0;
      cyc(); cyc();
      v1 = 1; a1 = 9; b1 = 1; op1 = 1;
      snap = rsp0_c;
      for (int i = 0; i < 5; i++) begin cyc(); chk("t5_stall_r1", req1_ready, 0); end
      chk("t5_hold_c", rsp0_c, snap);
      chk("t5_c", rsp0_c, 123);
      rr0 = 1;
      drain("t5_drain");
      chk("t5_c1", rsp1_c, 8);
    end

    // reset during EXEC drops the transaction; tie then goes to port 0
    v1 = 1; a1 = 1; b1 = 1; op1 = 0;
    cyc();
    chk("t6_exec", since, 0);
    rst_n = 0; cyc(); rst_n = 1;
    for (int i = 0; i < 3; i++) cyc();
    gnt_log.delete();
    v0 = 1; v1 = 1; new0(); new1();
    cyc();
    chk("t6_tie", (gnt_log.size() == 1) ? gnt_log[0] : 9, 0);
    drain("t6_drain");

    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      if (!v0 && $urandom_range(0, 2) == 0) begin v0 = 1; new0(); end
      if (!v1 && $urandom_range(0, 2) == 0) begin v1 = 1; new1(); end
      rr0 = ($urandom_range(0, 3) != 0);
      rr1 = ($urandom_range(0, 3) != 0);
      cyc();
    end
    rr0 = 1; rr1 = 1;
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
